// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stall sequencer states plus the opcode/funct
// encodings that the decoder and the hazard logic must agree on.
package pipeline_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_REFILL,
        ST_FILL,
        ST_MULDIV
    } stall_state_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes that occupy EX for multiple cycles
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;

    // True for any opcode that accesses the data cache in MEM
    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode == OP_LW) || (opcode == OP_LB) ||
               (opcode == OP_SW) || (opcode == OP_SB);
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the pipeline/cache/DRAM side (master) and the
// stall controller (slave).
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    // Pipeline / cache / memory status
    logic             mem_inst;
    logic             mem_is_write;
    logic             cache_hit;
    logic             dirty_victim;
    logic             dram_ready;
    logic             muldiv_start;
    logic             load_use;

    // Controller decisions
    logic             dram_req;
    logic             dram_we;
    logic             cache_fill_we;
    logic             stall;
    logic             pc_we;
    logic             hold_if;
    logic             bubble_ex;
    logic             miss_is_write;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output mem_inst, mem_is_write, cache_hit, dirty_victim, dram_ready,
               muldiv_start, load_use,
        input  dram_req, dram_we, cache_fill_we, stall, pc_we, hold_if,
               bubble_ex, miss_is_write, stall_cycles
    );

    modport slave (
        input  mem_inst, mem_is_write, cache_hit, dirty_victim, dram_ready,
               muldiv_start, load_use,
        output dram_req, dram_we, cache_fill_we, stall, pc_we, hold_if,
               bubble_ex, miss_is_write, stall_cycles
    );
endinterface

// File: rtl/muldiv_timer.sv
// Loadable down-counter that times a MULT/DIV occupying EX. It is loaded in
// the detection cycle, which already counts as one stall cycle, so the load
// value is MULDIV_LATENCY-2 and done rises after MULDIV_LATENCY-1 more cycles.
module muldiv_timer #(
    parameter int MULDIV_LATENCY = 32
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);
    localparam int CW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MULDIV_LATENCY - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise decrement down to zero and hold there
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Single owner of pipeline freeze: sequences D-cache miss service (victim
// writeback, refill, fill), fixed-latency MULT/DIV holds and load-use bubbles.
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_W          = 16
) (
    input logic                        clk,
    input logic                        rst_b,
    pipeline_stall_controller_if.slave bus
);

    stall_state_t     state_q, state_d;
    logic             muldiv_served_q, muldiv_served_d;
    logic             miss_is_write_q, miss_is_write_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic miss;
    logic md;
    logic stall;
    logic dram_req;
    logic dram_we;
    logic fill_we;
    logic tmr_load;
    logic tmr_en;
    logic tmr_done;

    muldiv_timer #(
        .MULDIV_LATENCY(MULDIV_LATENCY)
    ) u_muldiv_timer (
        .clk   (clk),
        .rst_b (rst_b),
        .load_i(tmr_load),
        .en_i  (tmr_en),
        .done_o(tmr_done)
    );

    // Next-state and stall outputs; a MEM miss beats a MULT/DIV because the
    // MEM instruction is older
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_d         = state_q;
        miss_is_write_d = miss_is_write_q;
        stall           = 1'b0;
        dram_req        = 1'b0;
        dram_we         = 1'b0;
        fill_we         = 1'b0;
        tmr_load        = 1'b0;
        tmr_en          = 1'b0;
        miss            = bus.mem_inst & ~bus.cache_hit;
        md              = bus.muldiv_start & ~muldiv_served_q;

        case (state_q)
            ST_IDLE: begin
                stall = miss | md;
                if (miss) begin
                    state_d         = bus.dirty_victim ? ST_WB : ST_REFILL;
                    miss_is_write_d = bus.mem_is_write;
                end else if (md) begin
                    state_d  = ST_MULDIV;
                    tmr_load = 1'b1;
                end
            end
            ST_WB: begin
                stall    = 1'b1;
                dram_req = 1'b1;
                dram_we  = 1'b1;
                if (bus.dram_ready) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                stall    = 1'b1;
                dram_req = 1'b1;
                if (bus.dram_ready) state_d = ST_FILL;
            end
            ST_FILL: begin
                stall   = 1'b1;
                fill_we = 1'b1;
                state_d = ST_IDLE;
            end
            ST_MULDIV: begin
                stall  = 1'b1;
                tmr_en = 1'b1;
                if (tmr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Served flag keeps a MULT/DIV still parked in EX from being timed twice;
    // it clears once EX is allowed to advance
    always_comb begin
        muldiv_served_d = muldiv_served_q;
        if ((state_q == ST_MULDIV) && tmr_done) begin
            muldiv_served_d = 1'b1;
        end else if (!stall) begin
            muldiv_served_d = 1'b0;
        end
    end

    // Saturating count of frozen cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers; reset abandons any DRAM transfer in flight
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q         <= ST_IDLE;
            muldiv_served_q <= 1'b0;
            miss_is_write_q <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            muldiv_served_q <= muldiv_served_d;
            miss_is_write_q <= miss_is_write_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // A stall suppresses the load-use bubble; the hazard is re-evaluated
    // once the pipeline releases
    assign bus.stall         = stall;
    assign bus.dram_req      = dram_req;
    assign bus.dram_we       = dram_we;
    assign bus.cache_fill_we = fill_we;
    assign bus.hold_if       = stall | bus.load_use;
    assign bus.pc_we         = ~(stall | bus.load_use);
    assign bus.bubble_ex     = bus.load_use & ~stall;
    assign bus.miss_is_write = miss_is_write_q;
    assign bus.stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller. Expected waveforms are
// built from the stall schedule of each scenario (detect, writeback cycles,
// refill cycles, fill, MULT/DIV latency) with a saturating stall-cycle tally.
module tb_pipeline_stall_controller;

    localparam int LAT = 4;
    localparam int CW  = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

    pipeline_stall_controller #(
        .MULDIV_LATENCY(LAT),
        .CNT_W         (CW)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    // {dram_req, dram_we, cache_fill_we, stall, pc_we, hold_if, bubble_ex}
    function automatic logic [6:0] obs();
        return {bus.dram_req, bus.dram_we, bus.cache_fill_we, bus.stall,
                bus.pc_we, bus.hold_if, bus.bubble_ex};
    endfunction

    function automatic logic [6:0] expv(input logic req, input logic we,
                                        input logic fill, input logic st,
                                        input logic lu);
        return {req, we, fill, st, ~(st | lu), st | lu, lu & ~st};
    endfunction

    task automatic set_in(input logic mi, input logic wr, input logic hit,
                          input logic dv, input logic rdy, input logic md,
                          input logic lu);
        bus.mem_inst     = mi;
        bus.mem_is_write = wr;
        bus.cache_hit    = hit;
        bus.dirty_victim = dv;
        bus.dram_ready   = rdy;
        bus.muldiv_start = md;
        bus.load_use     = lu;
        #1;
    endtask

    task automatic tick(input logic exp_stall);
        @(posedge clk);
        if (exp_stall && exp_cnt < CNT_MAX) exp_cnt++;
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== expv(0, 0, 0, 0, 0)) begin
            n_errors++;
            $display("FAIL reset_outputs act=%b exp=%b", obs(), expv(0, 0, 0, 0, 0));
        end
        n_checks++;
        if (bus.stall_cycles !== CW'(0) || bus.miss_is_write !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_regs cnt=%0d miw=%b exp cnt=0 miw=0",
                     bus.stall_cycles, bus.miss_is_write);
        end
        @(negedge clk);
        rst_b = 1'b1;
        exp_cnt = 0;
        tick(0);
    endtask

    // Miss service: detect, nwb writeback cycles (dirty only), nrf refill
    // cycles, one fill cycle, then release with cache_hit=1. If md is set a
    // MULT/DIV waits in EX throughout and is timed after the release.
    task automatic test_miss(input logic dirty, input int nwb, input int nrf,
                             input logic wr, input logic md);
        int nw;
        int total;
        logic lu, rdy, req, we, fill, wrin, dv;
        nw    = dirty ? nwb : 0;
        total = 1 + nw + nrf + 1;
        for (int k = 0; k < total; k++) begin
            lu   = (k == 0) ? 1'b1 : 1'($urandom);
            wrin = (k == 0) ? wr : 1'($urandom);
            dv   = (k == 0) ? dirty : 1'($urandom);
            if (k == 0 || k == total - 1) rdy = 1'($urandom);
            else if (k <= nw)             rdy = (k == nw);
            else                          rdy = (k == nw + nrf);
            req  = (k >= 1) && (k <= nw + nrf);
            we   = (k >= 1) && (k <= nw);
            fill = (k == total - 1);
            set_in(1, wrin, 0, dv, rdy, md, lu);
            n_checks++;
            if (obs() !== expv(req, we, fill, 1, lu)) begin
                n_errors++;
                $display("FAIL miss_cycle k=%0d dirty=%b act=%b exp=%b",
                         k, dirty, obs(), expv(req, we, fill, 1, lu));
            end
            n_checks++;
            if (bus.stall_cycles !== CW'(exp_cnt)) begin
                n_errors++;
                $display("FAIL miss_count k=%0d act=%0d exp=%0d", k, bus.stall_cycles, exp_cnt);
            end
            if (k >= 1) begin
                n_checks++;
                if (bus.miss_is_write !== wr) begin
                    n_errors++;
                    $display("FAIL miss_is_write k=%0d act=%b exp=%b", k, bus.miss_is_write, wr);
                end
            end
            tick(1);
        end
        if (md) begin
            for (int j = 0; j < LAT; j++) begin
                lu = 1'($urandom);
                set_in(1, 1'($urandom), 1, 1'($urandom), 1'($urandom), 1, lu);
                n_checks++;
                if (obs() !== expv(0, 0, 0, 1, lu)) begin
                    n_errors++;
                    $display("FAIL miss_then_muldiv j=%0d act=%b exp=%b", j, obs(), expv(0, 0, 0, 1, lu));
                end
                tick(1);
            end
        end
        lu = 1'($urandom);
        set_in(1, 1'($urandom), 1, 1'($urandom), 1'($urandom), md, lu);
        n_checks++;
        if (obs() !== expv(0, 0, 0, 0, lu)) begin
            n_errors++;
            $display("FAIL miss_release act=%b exp=%b", obs(), expv(0, 0, 0, 0, lu));
        end
        n_checks++;
        if (bus.stall_cycles !== CW'(exp_cnt) || bus.miss_is_write !== wr) begin
            n_errors++;
            $display("FAIL miss_release_regs cnt=%0d miw=%b exp cnt=%0d miw=%b",
                     bus.stall_cycles, bus.miss_is_write, exp_cnt, wr);
        end
        tick(0);
        set_in(0, 0, 1, 0, 0, 0, 0);
    endtask

    // MULT/DIV held in EX: exactly LAT stall cycles, then no re-stall while
    // muldiv_start stays high for one more cycle
    task automatic test_muldiv();
        logic lu;
        for (int k = 0; k <= LAT; k++) begin
            lu = 1'($urandom);
            set_in(1'($urandom), 0, 1, 0, 1'($urandom), 1, lu);
            n_checks++;
            if (obs() !== expv(0, 0, 0, (k < LAT), lu)) begin
                n_errors++;
                $display("FAIL muldiv k=%0d act=%b exp=%b", k, obs(), expv(0, 0, 0, (k < LAT), lu));
            end
            n_checks++;
            if (bus.stall_cycles !== CW'(exp_cnt)) begin
                n_errors++;
                $display("FAIL muldiv_count k=%0d act=%0d exp=%0d", k, bus.stall_cycles, exp_cnt);
            end
            tick(k < LAT);
        end
        set_in(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        set_in(0, 0, 1, 0, 0, 0, 1);
        n_checks++;
        if (obs() !== expv(0, 0, 0, 0, 1)) begin
            n_errors++;
            $display("FAIL load_use act=%b exp=%b", obs(), expv(0, 0, 0, 0, 1));
        end
        tick(0);
        set_in(0, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== expv(0, 0, 0, 0, 0) || bus.stall_cycles !== CW'(exp_cnt)) begin
            n_errors++;
            $display("FAIL load_use_after act=%b cnt=%0d exp=%b cnt=%0d",
                     obs(), bus.stall_cycles, expv(0, 0, 0, 0, 0), exp_cnt);
        end
        tick(0);
    endtask

    // Reset asserted mid-cycle during the second refill cycle
    task automatic test_reset_mid();
        set_in(1, 1, 0, 0, 0, 0, 0);
        tick(1);
        set_in(1, 1, 0, 0, 0, 0, 0);
        tick(1);
        set_in(1, 1, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.dram_req !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_pre dram_req act=%b exp=1", bus.dram_req);
        end
        #1;
        rst_b = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        exp_cnt = 0;
        n_checks++;
        if (obs() !== expv(0, 0, 0, 0, 0) || bus.stall_cycles !== CW'(0) ||
            bus.miss_is_write !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid act=%b cnt=%0d miw=%b exp=%b cnt=0 miw=0",
                     obs(), bus.stall_cycles, bus.miss_is_write, expv(0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_b = 1'b1;
        tick(0);
        set_in(0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (obs() !== expv(0, 0, 0, 0, 0) || bus.stall_cycles !== CW'(0)) begin
            n_errors++;
            $display("FAIL rst_mid_after act=%b cnt=%0d exp=%b cnt=0",
                     obs(), bus.stall_cycles, expv(0, 0, 0, 0, 0));
        end
        tick(0);
        set_in(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_idle_cycle();
        logic lu, mi;
        lu = 1'($urandom);
        mi = 1'($urandom);
        set_in(mi, 1'($urandom), 1, 1'($urandom), 1'($urandom), 0, lu);
        n_checks++;
        if (obs() !== expv(0, 0, 0, 0, lu) || bus.stall_cycles !== CW'(exp_cnt)) begin
            n_errors++;
            $display("FAIL idle act=%b cnt=%0d exp=%b cnt=%0d",
                     obs(), bus.stall_cycles, expv(0, 0, 0, 0, lu), exp_cnt);
        end
        tick(0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: test_miss(1'($urandom), $urandom_range(1, 4), $urandom_range(1, 4),
                             1'($urandom), 1'($urandom));
                1: test_muldiv();
                2: test_load_use();
                default: test_idle_cycle();
            endcase
        end
        // Drive the counter into saturation and confirm it holds there
        for (int i = 0; i < 20 && exp_cnt < CNT_MAX; i++) test_muldiv();
        test_miss(1, 2, 3, 0, 0);
        test_idle_cycle();
    endtask

    initial begin
        test_reset();
        test_miss(0, 0, 3, 0, 0);   // clean miss, 5 stall cycles
        test_miss(1, 2, 2, 1, 0);   // dirty miss, 6 stall cycles
        test_muldiv();
        test_miss(0, 0, 2, 0, 1);   // miss and MULT/DIV together
        test_load_use();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
